// File: rtl/simple_pkg.sv
`default_nettype none
// ============================================================================
// Module  : simple_pkg
// Purpose : Shared ALU opcode constants, instruction field encodings, FSM
//           state encoding and instruction decode helper for the core.
// Rev     : 1.0  initial release
// ============================================================================
package simple_pkg;

  // ALU operation selects, shared with the ALU
  localparam logic [3:0] IADD = 4'b0000;
  localparam logic [3:0] ISUB = 4'b0001;
  localparam logic [3:0] IAND = 4'b0010;
  localparam logic [3:0] IOR  = 4'b0011;
  localparam logic [3:0] IXOR = 4'b0100;
  localparam logic [3:0] ISLL = 4'b1000;
  localparam logic [3:0] ISLR = 4'b1001;
  localparam logic [3:0] ISRL = 4'b1010;
  localparam logic [3:0] ISRA = 4'b1011;
  localparam logic [3:0] IIDT = 4'b1100;
  localparam logic [3:0] INON = 4'b1111;

  // ALU-class op3 field encodings
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SLR = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Branch condition codes
  localparam logic [2:0] CC_BE  = 3'b000;
  localparam logic [2:0] CC_BLT = 3'b001;
  localparam logic [2:0] CC_BLE = 3'b010;
  localparam logic [2:0] CC_BNE = 3'b011;

  // Five-bit major opcode prefixes for non-ALU instructions
  localparam logic [4:0] PFX_LI  = 5'b10000;
  localparam logic [4:0] PFX_B   = 5'b10100;
  localparam logic [4:0] PFX_BCC = 5'b10111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_WB    = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  typedef struct packed {
    logic [3:0]  s_alu;
    logic [2:0]  rs;
    logic [2:0]  rd;
    logic [1:0]  sel_b;
    logic [15:0] imm;
    logic [2:0]  waddr;
    logic [15:0] boff;
    logic        we;
    logic        flag_upd;
    logic        halt;
    logic        uncond;
    logic        cond;
    logic [2:0]  cc;
  } dec_t;

  // Pure decode of an instruction word into control fields
  function automatic dec_t decode(input logic [15:0] ir);
    dec_t d;
    d       = '0;
    d.s_alu = INON;
    d.waddr = ir[10:8];
    d.boff  = {{8{ir[7]}}, ir[7:0]};
    if (ir[15:14] == 2'b11) begin
      d.rs = ir[13:11];
      d.rd = ir[10:8];
      case (ir[7:4])
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          d.s_alu    = ir[7:4];
          d.we       = 1'b1;
          d.flag_upd = 1'b1;
        end
        OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
          d.s_alu    = ir[7:4];
          d.sel_b    = 2'b01;
          d.imm      = {12'b0, ir[3:0]};
          d.we       = 1'b1;
          d.flag_upd = 1'b1;
        end
        OP_CMP: begin
          d.s_alu    = ISUB;
          d.flag_upd = 1'b1;
        end
        OP_MOV: begin
          // Identity passes operand B, so B must read the source register
          d.s_alu    = IIDT;
          d.rd       = ir[13:11];
          d.we       = 1'b1;
          d.flag_upd = 1'b1;
        end
        OP_HLT:  d.halt = 1'b1;
        default: d.s_alu = INON;
      endcase
    end else if (ir[15:11] == PFX_LI) begin
      d.s_alu = IIDT;
      d.sel_b = 2'b01;
      d.imm   = {{8{ir[7]}}, ir[7:0]};
      d.we    = 1'b1;
    end else if (ir[15:11] == PFX_B) begin
      d.uncond = 1'b1;
    end else if (ir[15:11] == PFX_BCC) begin
      d.cond = 1'b1;
      d.cc   = ir[10:8];
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// ============================================================================
// Module  : branch_cond
// Purpose : Evaluates a conditional-branch code against the flag register.
// Rev     : 1.0  initial release
// ============================================================================
module branch_cond
  import simple_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] cc,
  output logic       taken
);

  logic s, z, v;
  logic unused_carry;

  assign s            = flags[3];
  assign z            = flags[2];
  assign v            = flags[0];
  assign unused_carry = flags[1];

  // Condition table; codes 100-111 are never taken
  always_comb begin
    taken = 1'b0;
    case (cc)
      CC_BE:   taken = z;
      CC_BLT:  taken = s ^ v;
      CC_BLE:  taken = z | (s ^ v);
      CC_BNE:  taken = ~z;
      default: taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_unit
// Purpose : Three-state fetch/execute/write-back controller with branch,
//           flag register and halt handling.
// Rev     : 1.0  initial release
// ============================================================================
module ctrl_unit
  import simple_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] INSTR,
  input  logic [3:0]  ALU_FLAGS,
  input  logic        ALU_FLAG_WRITE,
  output logic [15:0] PC,
  output logic [3:0]  S_ALU,
  output logic [2:0]  RS_ADDR,
  output logic [2:0]  RD_ADDR,
  output logic [1:0]  SEL_B,
  output logic [15:0] IMM,
  output logic        REG_WE,
  output logic [2:0]  REG_WADDR,
  output logic [3:0]  FLAGS,
  output logic        HALTED
);

  state_t      state;
  logic [15:0] ir;
  logic [15:0] pc;
  logic [3:0]  flags_q;
  logic        halted_q;
  logic        we_q;
  logic        active;

  dec_t        dec;
  logic        cond_taken;
  logic        taken;
  logic [15:0] pc_next;

  // IR is held from the end of FETCH through WB, so decode stays stable
  assign dec = decode(ir);

  branch_cond u_branch_cond (
    .flags (flags_q),
    .cc    (dec.cc),
    .taken (cond_taken)
  );

  assign taken   = dec.uncond | (dec.cond & cond_taken);
  assign pc_next = pc + 16'd1 + (taken ? dec.boff : 16'd0);

  // Sequencer: owns PC, IR, flags, halt and the write-back strobe
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_FETCH;
      pc       <= 16'd0;
      ir       <= 16'd0;
      flags_q  <= 4'd0;
      halted_q <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          ir    <= INSTR;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (dec.halt) begin
            halted_q <= 1'b1;
            state    <= ST_HALT;
          end else begin
            we_q  <= dec.we;
            state <= ST_WB;
          end
        end
        ST_WB: begin
          we_q <= 1'b0;
          pc   <= pc_next;
          if (dec.flag_upd && ALU_FLAG_WRITE) begin
            flags_q <= ALU_FLAGS;
          end
          state <= ST_FETCH;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  assign active    = (state == ST_EXEC) || (state == ST_WB);
  assign S_ALU     = active ? dec.s_alu : INON;
  assign RS_ADDR   = dec.rs;
  assign RD_ADDR   = dec.rd;
  assign SEL_B     = dec.sel_b;
  assign IMM       = dec.imm;
  // A reset landing in WB must suppress the pending register write
  assign REG_WE    = we_q & ~RST;
  assign REG_WADDR = dec.waddr;
  assign PC        = pc;
  assign FLAGS     = flags_q;
  assign HALTED    = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_ctrl_unit
// Purpose : Directed self-checking bench for ctrl_unit.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ctrl_unit;

  logic        CLK;
  logic        RST;
  logic [15:0] INSTR;
  logic [3:0]  ALU_FLAGS;
  logic        ALU_FLAG_WRITE;
  logic [15:0] PC;
  logic [3:0]  S_ALU;
  logic [2:0]  RS_ADDR;
  logic [2:0]  RD_ADDR;
  logic [1:0]  SEL_B;
  logic [15:0] IMM;
  logic        REG_WE;
  logic [2:0]  REG_WADDR;
  logic [3:0]  FLAGS;
  logic        HALTED;

  int checks = 0;
  int errors = 0;

  // Values captured per instruction by run_instr
  logic [3:0]  f_s_alu, x_s_alu, w_s_alu;
  logic [2:0]  x_rs, x_rd, w_waddr;
  logic [1:0]  x_selb;
  logic [15:0] x_imm, p_pc;
  logic        w_we, p_we;
  logic [3:0]  p_flags;

  ctrl_unit dut (
    .CLK            (CLK),
    .RST            (RST),
    .INSTR          (INSTR),
    .ALU_FLAGS      (ALU_FLAGS),
    .ALU_FLAG_WRITE (ALU_FLAG_WRITE),
    .PC             (PC),
    .S_ALU          (S_ALU),
    .RS_ADDR        (RS_ADDR),
    .RD_ADDR        (RD_ADDR),
    .SEL_B          (SEL_B),
    .IMM            (IMM),
    .REG_WE         (REG_WE),
    .REG_WADDR      (REG_WADDR),
    .FLAGS          (FLAGS),
    .HALTED         (HALTED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    RST = 1'b1;
    INSTR = 16'h0000;
    ALU_FLAGS = 4'b0000;
    ALU_FLAG_WRITE = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  // Runs one non-halting instruction starting in FETCH, #1 after an edge
  task automatic run_instr(input logic [15:0] instr, input logic [3:0] af, input logic afw);
    INSTR = instr;
    ALU_FLAGS = af;
    ALU_FLAG_WRITE = afw;
    f_s_alu = S_ALU;
    @(posedge CLK); #1;
    x_s_alu = S_ALU; x_rs = RS_ADDR; x_rd = RD_ADDR; x_selb = SEL_B; x_imm = IMM;
    @(posedge CLK); #1;
    w_s_alu = S_ALU; w_we = REG_WE; w_waddr = REG_WADDR;
    @(posedge CLK); #1;
    p_pc = PC; p_flags = FLAGS; p_we = REG_WE;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (PC !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", PC); end
    checks++; if (FLAGS !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", FLAGS); end
    checks++; if (HALTED !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", HALTED); end
    checks++; if (REG_WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", REG_WE); end
    checks++; if (S_ALU !== 4'b1111) begin errors++; $display("FAIL reset_salu: got %b expected 1111", S_ALU); end
  endtask

  task automatic test_add();
    do_reset();
    run_instr(16'hCA00, 4'b0100, 1'b1);
    checks++; if (f_s_alu !== 4'b1111) begin errors++; $display("FAIL add_fetch_salu: got %b expected 1111", f_s_alu); end
    checks++; if (x_s_alu !== 4'b0000) begin errors++; $display("FAIL add_exec_salu: got %b expected 0000", x_s_alu); end
    checks++; if (x_rs !== 3'd1) begin errors++; $display("FAIL add_rs: got %0d expected 1", x_rs); end
    checks++; if (x_rd !== 3'd2) begin errors++; $display("FAIL add_rd: got %0d expected 2", x_rd); end
    checks++; if (x_selb !== 2'b00) begin errors++; $display("FAIL add_selb: got %b expected 00", x_selb); end
    checks++; if (w_s_alu !== 4'b0000) begin errors++; $display("FAIL add_wb_salu: got %b expected 0000", w_s_alu); end
    checks++; if (w_we !== 1'b1) begin errors++; $display("FAIL add_wb_we: got %b expected 1", w_we); end
    checks++; if (w_waddr !== 3'd2) begin errors++; $display("FAIL add_waddr: got %0d expected 2", w_waddr); end
    checks++; if (p_flags !== 4'b0100) begin errors++; $display("FAIL add_flags: got %b expected 0100", p_flags); end
    checks++; if (p_pc !== 16'h0001) begin errors++; $display("FAIL add_pc: got %h expected 0001", p_pc); end
    checks++; if (p_we !== 1'b0) begin errors++; $display("FAIL add_we_pulse: got %b expected 0", p_we); end
  endtask

  task automatic test_branch();
    // CMP sets Z, BE +5 taken: PC 1 -> 7
    do_reset();
    run_instr(16'hCA50, 4'b0100, 1'b1);
    checks++; if (x_s_alu !== 4'b0001) begin errors++; $display("FAIL cmp_salu: got %b expected 0001", x_s_alu); end
    checks++; if (w_we !== 1'b0) begin errors++; $display("FAIL cmp_we: got %b expected 0", w_we); end
    checks++; if (p_flags !== 4'b0100) begin errors++; $display("FAIL cmp_flags: got %b expected 0100", p_flags); end
    checks++; if (p_pc !== 16'h0001) begin errors++; $display("FAIL cmp_pc: got %h expected 0001", p_pc); end
    run_instr(16'hB805, 4'b1111, 1'b1);
    checks++; if (x_s_alu !== 4'b1111) begin errors++; $display("FAIL be_salu: got %b expected 1111", x_s_alu); end
    checks++; if (w_we !== 1'b0) begin errors++; $display("FAIL be_we: got %b expected 0", w_we); end
    checks++; if (p_pc !== 16'h0007) begin errors++; $display("FAIL be_taken_pc: got %h expected 0007", p_pc); end
    checks++; if (p_flags !== 4'b0100) begin errors++; $display("FAIL be_flags_kept: got %b expected 0100", p_flags); end
    // CMP clears Z, BE not taken: PC 1 -> 2
    do_reset();
    run_instr(16'hCA50, 4'b0000, 1'b1);
    run_instr(16'hB805, 4'b0100, 1'b1);
    checks++; if (p_pc !== 16'h0002) begin errors++; $display("FAIL be_not_taken_pc: got %h expected 0002", p_pc); end
    // BLT with S^V=0 not taken: PC 2 -> 3
    run_instr(16'hB903, 4'b0000, 1'b0);
    checks++; if (p_pc !== 16'h0003) begin errors++; $display("FAIL blt_not_taken_pc: got %h expected 0003", p_pc); end
    // CMP sets S only, then BLT +3 taken from PC 4: 4+1+3 = 8
    run_instr(16'hCA50, 4'b1000, 1'b1);
    run_instr(16'hB903, 4'b0000, 1'b0);
    checks++; if (p_pc !== 16'h0008) begin errors++; $display("FAIL blt_taken_pc: got %h expected 0008", p_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    run_instr(16'hA0FE, 4'b0000, 1'b0);
    checks++; if (p_pc !== 16'hFFFF) begin errors++; $display("FAIL b_back_pc: got %h expected ffff", p_pc); end
    run_instr(16'hA0FF, 4'b0000, 1'b0);
    checks++; if (p_pc !== 16'hFFFF) begin errors++; $display("FAIL b_minus1_pc: got %h expected ffff", p_pc); end
    run_instr(16'h0000, 4'b1111, 1'b1);
    checks++; if (x_s_alu !== 4'b1111) begin errors++; $display("FAIL nop_salu: got %b expected 1111", x_s_alu); end
    checks++; if (w_we !== 1'b0) begin errors++; $display("FAIL nop_we: got %b expected 0", w_we); end
    checks++; if (p_pc !== 16'h0000) begin errors++; $display("FAIL nop_wrap_pc: got %h expected 0000", p_pc); end
    checks++; if (p_flags !== 4'b0000) begin errors++; $display("FAIL nop_flags: got %b expected 0000", p_flags); end
  endtask

  task automatic test_li_mov();
    do_reset();
    run_instr(16'h8380, 4'b1111, 1'b1);
    checks++; if (x_s_alu !== 4'b1100) begin errors++; $display("FAIL li_salu: got %b expected 1100", x_s_alu); end
    checks++; if (x_selb !== 2'b01) begin errors++; $display("FAIL li_selb: got %b expected 01", x_selb); end
    checks++; if (x_imm !== 16'hFF80) begin errors++; $display("FAIL li_imm: got %h expected ff80", x_imm); end
    checks++; if (w_we !== 1'b1 || w_waddr !== 3'd3) begin errors++; $display("FAIL li_write: got we=%b addr=%0d expected we=1 addr=3", w_we, w_waddr); end
    checks++; if (p_flags !== 4'b0000) begin errors++; $display("FAIL li_flags: got %b expected 0000", p_flags); end
    run_instr(16'hEA60, 4'b1111, 1'b0);
    checks++; if (x_s_alu !== 4'b1100) begin errors++; $display("FAIL mov_salu: got %b expected 1100", x_s_alu); end
    checks++; if (x_selb !== 2'b00) begin errors++; $display("FAIL mov_selb: got %b expected 00", x_selb); end
    checks++; if (x_rd !== 3'd5) begin errors++; $display("FAIL mov_b_addr: got %0d expected 5", x_rd); end
    checks++; if (w_we !== 1'b1 || w_waddr !== 3'd2) begin errors++; $display("FAIL mov_write: got we=%b addr=%0d expected we=1 addr=2", w_we, w_waddr); end
    checks++; if (p_flags !== 4'b0000) begin errors++; $display("FAIL mov_no_strobe_flags: got %b expected 0000", p_flags); end
    run_instr(16'hEA70, 4'b1111, 1'b1);
    checks++; if (x_s_alu !== 4'b1111 || w_we !== 1'b0) begin errors++; $display("FAIL undef_op: got salu=%b we=%b expected salu=1111 we=0", x_s_alu, w_we); end
    checks++; if (p_flags !== 4'b0000 || p_pc !== 16'h0003) begin errors++; $display("FAIL undef_state: got flags=%b pc=%h expected flags=0000 pc=0003", p_flags, p_pc); end
  endtask

  task automatic test_shift_halt();
    do_reset();
    run_instr(16'hC0B3, 4'b0010, 1'b1);
    checks++; if (x_s_alu !== 4'b1011) begin errors++; $display("FAIL sra_salu: got %b expected 1011", x_s_alu); end
    checks++; if (x_selb !== 2'b01) begin errors++; $display("FAIL sra_selb: got %b expected 01", x_selb); end
    checks++; if (x_imm !== 16'h0003) begin errors++; $display("FAIL sra_imm: got %h expected 0003", x_imm); end
    checks++; if (w_we !== 1'b1) begin errors++; $display("FAIL sra_we: got %b expected 1", w_we); end
    checks++; if (p_flags !== 4'b0010) begin errors++; $display("FAIL sra_flags: got %b expected 0010", p_flags); end
    INSTR = 16'hC0F0;
    ALU_FLAGS = 4'b1111;
    ALU_FLAG_WRITE = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    checks++; if (HALTED !== 1'b1) begin errors++; $display("FAIL hlt_halted: got %b expected 1", HALTED); end
    INSTR = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      checks++; if (PC !== 16'h0001 || HALTED !== 1'b1 || FLAGS !== 4'b0010 || REG_WE !== 1'b0) begin
        errors++;
        $display("FAIL hlt_frozen[%0d]: got pc=%h halted=%b flags=%b we=%b expected pc=0001 halted=1 flags=0010 we=0", i, PC, HALTED, FLAGS, REG_WE);
      end
    end
    do_reset();
    checks++; if (PC !== 16'h0000 || HALTED !== 1'b0) begin errors++; $display("FAIL hlt_reset: got pc=%h halted=%b expected pc=0000 halted=0", PC, HALTED); end
  endtask

  task automatic test_reset_in_wb();
    do_reset();
    INSTR = 16'hCA00;
    ALU_FLAGS = 4'b1111;
    ALU_FLAG_WRITE = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    checks++; if (REG_WE !== 1'b1) begin errors++; $display("FAIL wb_we_before_rst: got %b expected 1", REG_WE); end
    RST = 1'b1;
    #1;
    checks++; if (REG_WE !== 1'b0) begin errors++; $display("FAIL wb_we_under_rst: got %b expected 0", REG_WE); end
    @(posedge CLK); #1;
    RST = 1'b0;
    checks++; if (PC !== 16'h0000 || FLAGS !== 4'b0000) begin errors++; $display("FAIL wb_rst_state: got pc=%h flags=%b expected pc=0000 flags=0000", PC, FLAGS); end
    checks++; if (REG_WE !== 1'b0 || S_ALU !== 4'b1111) begin errors++; $display("FAIL wb_rst_outputs: got we=%b salu=%b expected we=0 salu=1111", REG_WE, S_ALU); end
    run_instr(16'h0000, 4'b0000, 1'b0);
    checks++; if (p_pc !== 16'h0001) begin errors++; $display("FAIL wb_rst_refetch: got pc=%h expected 0001", p_pc); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_wrap();
    test_li_mov();
    test_shift_halt();
    test_reset_in_wb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have port CLK, input, 1, rising-edge clock.
REQ-003 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-004 SHALL have port INSTR, input, 16, instruction word at address PC, valid during FETCH.
REQ-005 SHALL have port ALU_FLAGS, input, 4, ALU flags {S,Z,C,V}.
REQ-006 SHALL have port ALU_FLAG_WRITE, input, 1, ALU flag-valid strobe.
REQ-007 SHALL have port PC, output, 16, program counter.
REQ-008 SHALL have port S_ALU, output, 4, ALU operation select.
REQ-009 SHALL have ports RS_ADDR and RD_ADDR, output, 3 each, register-file read addresses for ALU inputs A and B.
REQ-010 SHALL have port SEL_B, output, 2, ALU B-operand source: 00 register, 01 IMM.
REQ-011 SHALL have port IMM, output, 16, immediate value.
REQ-012 SHALL have ports REG_WE (output, 1) and REG_WADDR (output, 3), register write-back strobe and address.
REQ-013 SHALL have ports FLAGS (output, 4, architectural flag register) and HALTED (output, 1).

Function
REQ-014 Instruction execution SHALL be a 3-state FSM: FETCH -> EXEC -> WB -> FETCH, plus terminal HALT; one instruction per 3 cycles.
REQ-015 In FETCH, IR SHALL capture INSTR at the clock edge; S_ALU SHALL be INON (1111).
REQ-016 In EXEC and WB, S_ALU/RS_ADDR/RD_ADDR/SEL_B/IMM SHALL be decoded from IR and held stable.
REQ-017 ALU class (IR[15:14]=11): RS_ADDR=IR[13:11]; RD_ADDR=IR[10:8]; op3=IR[7:4].
REQ-018 op3 mapping: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 1000 SLL, 1001 SLR, 1010 SRL, 1011 SRA -> S_ALU=op3, writes rd, except shifts use SEL_B=01 with IMM={12'b0,IR[3:0]}.
REQ-019 op3 0101 CMP SHALL drive SUB (0001), update FLAGS, and leave REG_WE low.
REQ-020 op3 0110 MOV SHALL drive IDT (1100), SEL_B=00, B=RS, and write rd.
REQ-021 op3 1111 HLT SHALL transition EXEC -> HALT; PC and FLAGS are then frozen, HALTED=1, and only RST exits.
REQ-022 All other op3 values and IR[15:14]=00/01 SHALL behave as NOP: S_ALU=INON, no write, PC+1.
REQ-023 LI (IR[15:11]=10000): S_ALU=IDT, SEL_B=01, IMM=sign-extend(IR[7:0]), write IR[10:8]; FLAGS unchanged.
REQ-024 B (IR[15:11]=10100) and Bcc (IR[15:11]=10111, cc=IR[10:8]) SHALL use S_ALU=INON; cc 000 BE (Z), 001 BLT (S^V), 010 BLE (Z|(S^V)), 011 BNE (!Z); cc 100-111 not taken.
REQ-025 Branch conditions SHALL be evaluated on the FLAGS register, not on ALU_FLAGS.
REQ-026 In WB, PC SHALL become PC+1+sign-extend(IR[7:0]) when taken, else PC+1; arithmetic is mod 2^16.
REQ-027 In WB, REG_WE SHALL be 1 for exactly one cycle for writing instructions, with REG_WADDR=IR[10:8].
REQ-028 In WB, FLAGS SHALL load ALU_FLAGS iff the instruction is ALU-class non-NOP (incl. CMP) and ALU_FLAG_WRITE=1.
REQ-029 The flag update and branch evaluation rules SHALL guarantee that a branch immediately after a flag-setting instruction sees the updated flags.

Reset
REQ-030 RST=1 at any clock edge SHALL force FETCH, PC=0, IR=0, FLAGS=0, HALTED=0, REG_WE=0, and S_ALU=INON; this overrides HALT and mid-instruction states with no partial write-back.

Structure
REQ-031 ALU opcode constants (IADD...INON), op3/cc encodings, and FSM state encoding SHALL live in shared package simple_pkg, also used by the ALU.
REQ-032 Condition evaluation SHALL be a sub-module branch_cond (inputs FLAGS and cc, output taken).

Verification
REQ-033 Reset: hold RST 2 cycles -> PC=0, FLAGS=0, HALTED=0, REG_WE=0.
REQ-034 ADD r1,r2 (INSTR=16'hCA00) with ALU_FLAGS=4'b0100 and ALU_FLAG_WRITE=1 -> EXEC S_ALU=0000, RS=1, RD=2; WB REG_WE=1, REG_WADDR=2, FLAGS=0100, PC=1.
REQ-035 CMP, then BE +5 (INSTR=16'hB805) with Z=1 -> PC goes 1 -> 7; repeat with Z=0 -> PC goes 1 -> 2.
REQ-036 PC=16'hFFFF, B -1 (16'hA0FF) -> PC=16'hFFFF; PC=16'hFFFF, NOP -> PC=0 (wrap).
REQ-037 SRA d=3 (16'hC0B3) -> SEL_B=01, IMM=3; HLT (16'hC0F0) -> HALTED=1, PC frozen for 10 cycles; RST -> PC=0.
REQ-038 RST asserted during WB of a writing instruction -> no REG_WE pulse, FETCH next.
